apb_protocol: RTL and testbench



---
 rtl/apb_protocol_pkg.sv | 34 +++
 rtl/apb_uart_slave.sv | 246 ++++++++++++++++++++++++
 rtl/apb_protocol.sv | 157 +++++++++++++++
 tb/tb_apb_protocol.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_protocol_pkg.sv
// ---------------------------------------------------------------------------
// apb_protocol_pkg
// Shared types and constants for the APB subsystem:
//   - master FSM state encoding (IDLE / SETUP / ACCESS)
//   - UART receiver state encoding (IDLE / DATA / STOP)
//   - slave select codes and bus/address widths
//   - psel_valid(): true when Psel addresses an existing slave
// ---------------------------------------------------------------------------
package apb_protocol_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [1:0] PSEL_MEM  = 2'b01;
  localparam logic [1:0] PSEL_UART = 2'b10;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'b00,
    APB_SETUP  = 2'b01,
    APB_ACCESS = 2'b10
  } apb_state_e;

  typedef enum logic [1:0] {
    RX_IDLE = 2'b00,
    RX_DATA = 2'b01,
    RX_STOP = 2'b10
  } uart_rx_state_e;

  // Only the two one-hot select codes reach a slave; 00 and 11 select nothing.
  function automatic logic psel_valid(input logic [1:0] psel);
    return (psel == PSEL_MEM) || (psel == PSEL_UART);
  endfunction

endpackage

// File: rtl/apb_uart_slave.sv
// ---------------------------------------------------------------------------
// apb_uart_slave
// UART slave of the APB subsystem. One bit per clock, no oversampling.
//   clk      in   bus clock
//   rst      in   synchronous active-high reset (aborts frames, empties FIFOs)
//   wr_en    in   one-cycle strobe: push wr_byte into the TX FIFO
//   wr_byte  in   byte to transmit
//   rd_en    in   one-cycle strobe: pop the RX FIFO
//   rx       in   serial input, idle high
//   rd_byte  out  head of the RX FIFO, or 0 when the FIFO is empty
//   tx       out  serial output, idle high (start 0, 8 data LSB first, stop 1)
// ---------------------------------------------------------------------------
module apb_uart_slave
  import apb_protocol_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 8,
  parameter int TX_FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_byte,
  input  logic       rd_en,
  input  logic       rx,
  output logic [7:0] rd_byte,
  output logic       tx
);

  localparam int RX_AW = $clog2(RX_FIFO_DEPTH);
  localparam int TX_AW = $clog2(TX_FIFO_DEPTH);

  localparam logic [RX_AW:0]   RX_FULL    = (RX_AW + 1)'(RX_FIFO_DEPTH);
  localparam logic [RX_AW:0]   RX_EMPTY   = (RX_AW + 1)'(0);
  localparam logic [RX_AW:0]   RX_CNT_ONE = (RX_AW + 1)'(1);
  localparam logic [RX_AW-1:0] RX_PTR_ONE = RX_AW'(1);
  localparam logic [TX_AW:0]   TX_FULL    = (TX_AW + 1)'(TX_FIFO_DEPTH);
  localparam logic [TX_AW:0]   TX_EMPTY   = (TX_AW + 1)'(0);
  localparam logic [TX_AW:0]   TX_CNT_ONE = (TX_AW + 1)'(1);
  localparam logic [TX_AW-1:0] TX_PTR_ONE = TX_AW'(1);

  // ---------------- RX deserializer ----------------
  uart_rx_state_e rx_state_q, rx_state_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic           rx_push_s;

  // Frame tracking: start bit opens DATA, eight shifts, then stop-bit check.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push_s  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx) begin
          rx_state_d = RX_DATA;
          rx_bit_d   = 3'd0;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        // LSB arrives first, so shifting in from the top leaves bit 0 at [0].
        rx_shift_d = {rx, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) begin
          rx_state_d = RX_STOP;
        end else begin
          rx_state_d = RX_DATA;
        end
      end
      RX_STOP: begin
        // A low stop bit is a framing error: the byte is silently dropped.
        if (rx) begin
          rx_push_s = 1'b1;
        end else begin
          rx_push_s = 1'b0;
        end
        rx_state_d = RX_IDLE;
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      rx_state_q <= rx_state_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]       rx_mem_q [RX_FIFO_DEPTH];
  logic [7:0]       rx_mem_d [RX_FIFO_DEPTH];
  logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
  logic             rx_pop_s, rx_push_ok_s;

  // An empty FIFO cannot be popped, even if a byte lands on the same edge;
  // a full FIFO accepts a push only when a pop frees a slot on that edge.
  assign rx_pop_s     = rd_en && (rx_cnt_q != RX_EMPTY);
  assign rx_push_ok_s = rx_push_s && ((rx_cnt_q != RX_FULL) || rx_pop_s);
  assign rd_byte      = (rx_cnt_q != RX_EMPTY) ? rx_mem_q[rx_rptr_q] : 8'h00;

  // RX FIFO pointer/count/storage update.
  always_comb begin
    rx_mem_d  = rx_mem_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    if (rx_push_ok_s) begin
      rx_mem_d[rx_wptr_q] = rx_shift_q;
      rx_wptr_d           = rx_wptr_q + RX_PTR_ONE;
    end else begin
      rx_wptr_d = rx_wptr_q;
    end
    if (rx_pop_s) begin
      rx_rptr_d = rx_rptr_q + RX_PTR_ONE;
    end else begin
      rx_rptr_d = rx_rptr_q;
    end
    case ({rx_push_ok_s, rx_pop_s})
      2'b10:   rx_cnt_d = rx_cnt_q + RX_CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - RX_CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // RX FIFO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_mem_q  <= '{default: 8'h00};
      rx_wptr_q <= RX_AW'(0);
      rx_rptr_q <= RX_AW'(0);
      rx_cnt_q  <= RX_EMPTY;
    end else begin
      rx_mem_q  <= rx_mem_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]       tx_mem_q [TX_FIFO_DEPTH];
  logic [7:0]       tx_mem_d [TX_FIFO_DEPTH];
  logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
  logic             tx_pop_s, tx_push_ok_s;

  // TX serializer registers (declared here because the pop depends on them).
  logic       tx_busy_q, tx_busy_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic [9:0] tx_frame_q, tx_frame_d;

  // The serializer takes the next byte when idle or while its stop bit is on
  // the line, giving back-to-back frames with no idle gap.
  assign tx_pop_s     = (tx_cnt_q != TX_EMPTY) && (!tx_busy_q || (tx_bit_q == 4'd9));
  assign tx_push_ok_s = wr_en && ((tx_cnt_q != TX_FULL) || tx_pop_s);

  // TX FIFO pointer/count/storage update.
  always_comb begin
    tx_mem_d  = tx_mem_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    if (tx_push_ok_s) begin
      tx_mem_d[tx_wptr_q] = wr_byte;
      tx_wptr_d           = tx_wptr_q + TX_PTR_ONE;
    end else begin
      tx_wptr_d = tx_wptr_q;
    end
    if (tx_pop_s) begin
      tx_rptr_d = tx_rptr_q + TX_PTR_ONE;
    end else begin
      tx_rptr_d = tx_rptr_q;
    end
    case ({tx_push_ok_s, tx_pop_s})
      2'b10:   tx_cnt_d = tx_cnt_q + TX_CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - TX_CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // TX FIFO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_mem_q  <= '{default: 8'h00};
      tx_wptr_q <= TX_AW'(0);
      tx_rptr_q <= TX_AW'(0);
      tx_cnt_q  <= TX_EMPTY;
    end else begin
      tx_mem_q  <= tx_mem_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
    end
  end

  // ---------------- TX serializer ----------------
  // The line is bit 0 of a 10-bit frame register that shifts in ones, so the
  // register is all ones (line high) once a frame has fully gone out.
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_bit_d   = tx_bit_q;
    tx_frame_d = tx_frame_q;
    if (tx_pop_s) begin
      tx_frame_d = {1'b1, tx_mem_q[tx_rptr_q], 1'b0};
      tx_bit_d   = 4'd0;
      tx_busy_d  = 1'b1;
    end else if (tx_busy_q) begin
      if (tx_bit_q == 4'd9) begin
        tx_busy_d  = 1'b0;
        tx_bit_d   = 4'd0;
        tx_frame_d = 10'h3FF;
      end else begin
        tx_frame_d = {1'b1, tx_frame_q[9:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
      end
    end else begin
      tx_frame_d = 10'h3FF;
    end
  end

  // Serializer registers; the line itself comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy_q  <= 1'b0;
      tx_bit_q   <= 4'd0;
      tx_frame_q <= 10'h3FF;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_bit_q   <= tx_bit_d;
      tx_frame_q <= tx_frame_d;
    end
  end

  assign tx = tx_frame_q[0];

endmodule

// File: rtl/apb_protocol.sv
// ---------------------------------------------------------------------------
// apb_protocol
// APB subsystem top: master FSM driven by external strobes, a 32-word
// register memory (Psel=01) and a UART slave (Psel=10).
//   pclk               in   bus clock, rising edge
//   Reset              in   synchronous active-high reset
//   penable            in   moves SETUP to ACCESS
//   pwrite             in   1 = write, 0 = read
//   transfer           in   transaction request
//   write_paddr        in   memory write address
//   apb_read_paddr     in   memory read address
//   write_data         in   write data (UART uses [7:0])
//   Psel               in   slave select: 01 memory, 10 UART, else none
//   rx                 in   UART serial input, idle high
//   apb_read_data_out  out  registered read data, holds between reads
// ---------------------------------------------------------------------------
module apb_protocol
  import apb_protocol_pkg::*;
#(
  parameter int MEM_DEPTH     = 32,
  parameter int RX_FIFO_DEPTH = 8,
  parameter int TX_FIFO_DEPTH = 16
) (
  input  logic              pclk,
  input  logic              Reset,
  input  logic              penable,
  input  logic              pwrite,
  input  logic              transfer,
  input  logic [ADDR_W-1:0] write_paddr,
  input  logic [ADDR_W-1:0] apb_read_paddr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [1:0]        Psel,
  output logic [DATA_W-1:0] apb_read_data_out,
  input  logic              rx
);

  apb_state_e state_q, state_d;

  // Master FSM next state. An abort in SETUP wins over penable.
  always_comb begin
    state_d = state_q;
    case (state_q)
      APB_IDLE: begin
        if (transfer && psel_valid(Psel)) begin
          state_d = APB_SETUP;
        end else begin
          state_d = APB_IDLE;
        end
      end
      APB_SETUP: begin
        if (!transfer || !psel_valid(Psel)) begin
          state_d = APB_IDLE;
        end else if (penable) begin
          state_d = APB_ACCESS;
        end else begin
          state_d = APB_SETUP;
        end
      end
      APB_ACCESS: begin
        if (transfer) begin
          state_d = APB_SETUP;
        end else begin
          state_d = APB_IDLE;
        end
      end
      default: begin
        state_d = APB_IDLE;
      end
    endcase
  end

  // Master state register.
  always_ff @(posedge pclk) begin
    if (Reset) begin
      state_q <= APB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The single operation of a transfer happens on the edge leaving ACCESS,
  // using Psel/pwrite/addresses/data as seen on that edge.
  logic access_s, mem_wr_s, mem_rd_s, uart_wr_s, uart_rd_s;
  assign access_s  = (state_q == APB_ACCESS);
  assign mem_wr_s  = access_s && (Psel == PSEL_MEM)  &&  pwrite;
  assign mem_rd_s  = access_s && (Psel == PSEL_MEM)  && !pwrite;
  assign uart_wr_s = access_s && (Psel == PSEL_UART) &&  pwrite;
  assign uart_rd_s = access_s && (Psel == PSEL_UART) && !pwrite;

  // ---------------- Memory slave ----------------
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] mem_d [MEM_DEPTH];

  // Memory write path.
  always_comb begin
    mem_d = mem_q;
    if (mem_wr_s) begin
      mem_d[write_paddr] = write_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Memory storage.
  always_ff @(posedge pclk) begin
    if (Reset) begin
      mem_q <= '{default: 32'h0000_0000};
    end else begin
      mem_q <= mem_d;
    end
  end

  // ---------------- UART slave ----------------
  logic [7:0] uart_rd_byte;
  logic       uart_tx;

  apb_uart_slave #(
    .RX_FIFO_DEPTH (RX_FIFO_DEPTH),
    .TX_FIFO_DEPTH (TX_FIFO_DEPTH)
  ) u_uart (
    .clk     (pclk),
    .rst     (Reset),
    .wr_en   (uart_wr_s),
    .wr_byte (write_data[7:0]),
    .rd_en   (uart_rd_s),
    .rx      (rx),
    .rd_byte (uart_rd_byte),
    .tx      (uart_tx)
  );

  // ---------------- Read data register ----------------
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Read data mux; holds its value on writes and on invalid selects.
  always_comb begin
    rdata_d = rdata_q;
    if (mem_rd_s) begin
      rdata_d = mem_q[apb_read_paddr];
    end else if (uart_rd_s) begin
      rdata_d = {24'h00_0000, uart_rd_byte};
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register.
  always_ff @(posedge pclk) begin
    if (Reset) begin
      rdata_q <= 32'h0000_0000;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign apb_read_data_out = rdata_q;

endmodule

// File: tb/tb_apb_protocol.sv
// ---------------------------------------------------------------------------
// tb_apb_protocol
// Directed bench for apb_protocol. Inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_apb_protocol;

  logic        pclk = 1'b0;
  logic        Reset;
  logic        penable;
  logic        pwrite;
  logic        transfer;
  logic [4:0]  write_paddr;
  logic [4:0]  apb_read_paddr;
  logic [31:0] write_data;
  logic [1:0]  Psel;
  logic [31:0] apb_read_data_out;
  logic        rx;

  int n_cmp = 0;
  int n_bad = 0;

  apb_protocol dut (
    .pclk              (pclk),
    .Reset             (Reset),
    .penable           (penable),
    .pwrite            (pwrite),
    .transfer          (transfer),
    .write_paddr       (write_paddr),
    .apb_read_paddr    (apb_read_paddr),
    .write_data        (write_data),
    .Psel              (Psel),
    .apb_read_data_out (apb_read_data_out),
    .rx                (rx)
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One complete transfer from IDLE: SETUP, ACCESS, operation, back to IDLE.
  task automatic apb_op(input logic [1:0] sel, input logic wr, input logic [4:0] addr,
                        input logic [31:0] data);
    Psel = sel; pwrite = wr; write_paddr = addr; apb_read_paddr = addr;
    write_data = data; transfer = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    penable = 1'b0; transfer = 1'b0;
    tick();
  endtask

  // Serial frame on rx: start 0, data LSB first, then the given stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick();
    end
    rx = stop;
    tick();
    rx = 1'b1;
  endtask

  initial begin
    logic [7:0] tx_byte;
    Reset = 1'b1; penable = 1'b0; pwrite = 1'b0; transfer = 1'b0;
    write_paddr = 5'd0; apb_read_paddr = 5'd0; write_data = 32'h0; Psel = 2'b00; rx = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    check_eq("reset_out", apb_read_data_out, 32'h0000_0000);
    check_eq("reset_tx_idle", {31'h0, dut.uart_tx}, 32'h0000_0001);

    // Strobes held high for three cycles: exactly one write.
    Psel = 2'b01; transfer = 1'b1; penable = 1'b1; pwrite = 1'b1;
    write_paddr = 5'd1; write_data = 32'hEF13_1025;
    tick(); tick(); tick();
    transfer = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tick();
    check_eq("write_no_out", apb_read_data_out, 32'h0000_0000);
    apb_op(2'b01, 1'b0, 5'd1, 32'h0);
    check_eq("read_a1", apb_read_data_out, 32'hEF13_1025);

    apb_op(2'b01, 1'b1, 5'd2, 32'h0000_0AAA);
    apb_op(2'b01, 1'b0, 5'd2, 32'h0);
    check_eq("read_a2", apb_read_data_out, 32'h0000_0AAA);
    apb_op(2'b01, 1'b0, 5'd1, 32'h0);
    check_eq("reread_a1", apb_read_data_out, 32'hEF13_1025);
    apb_op(2'b01, 1'b1, 5'd2, 32'h0000_0AAA);
    apb_op(2'b01, 1'b0, 5'd2, 32'h0);
    check_eq("idempotent_a2", apb_read_data_out, 32'h0000_0AAA);
    apb_op(2'b01, 1'b1, 5'd31, 32'hFFFF_FFFF);
    apb_op(2'b01, 1'b0, 5'd0, 32'h0);
    check_eq("read_a0_unwritten", apb_read_data_out, 32'h0000_0000);
    apb_op(2'b01, 1'b0, 5'd31, 32'h0);
    check_eq("read_a31", apb_read_data_out, 32'hFFFF_FFFF);

    // Psel dropped to 00 during ACCESS of a read: output must hold.
    Psel = 2'b01; pwrite = 1'b0; apb_read_paddr = 5'd2; transfer = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    Psel = 2'b00; penable = 1'b0; transfer = 1'b0;
    tick();
    check_eq("invalid_psel_read_hold", apb_read_data_out, 32'hFFFF_FFFF);

    // Psel changed to 11 during ACCESS of a write: memory untouched.
    Psel = 2'b01; pwrite = 1'b1; write_paddr = 5'd3; write_data = 32'h1234_5678;
    transfer = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    Psel = 2'b11; penable = 1'b0; transfer = 1'b0;
    tick();
    apb_op(2'b01, 1'b0, 5'd3, 32'h0);
    check_eq("invalid_psel_write_dropped", apb_read_data_out, 32'h0000_0000);

    // UART write of 0xA5, then watch the frame on the internal tx line.
    apb_op(2'b01, 1'b0, 5'd1, 32'h0);
    apb_op(2'b10, 1'b1, 5'd0, 32'h0000_00A5);
    check_eq("uart_wr_no_out", apb_read_data_out, 32'hEF13_1025);
    for (int n = 0; n < 20 && dut.uart_tx !== 1'b0; n++) tick();
    check_eq("tx_start", {31'h0, dut.uart_tx}, 32'h0000_0000);
    tx_byte = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("tx_bit%0d", i), {31'h0, dut.uart_tx}, {31'h0, tx_byte[i]});
    end
    tick();
    check_eq("tx_stop", {31'h0, dut.uart_tx}, 32'h0000_0001);
    tick();
    check_eq("tx_idle_after", {31'h0, dut.uart_tx}, 32'h0000_0001);

    // Ten UART writes, one-cycle penable pulse each, transfer held high.
    Psel = 2'b10; pwrite = 1'b1; transfer = 1'b1; penable = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      write_data = {24'h0, 8'($urandom_range(0, 255))};
      penable = 1'b1;
      tick();
      penable = 1'b0;
      tick();
    end
    transfer = 1'b0;
    tick();
    check_eq("uart_10wr_no_out", apb_read_data_out, 32'hEF13_1025);

    apb_op(2'b10, 1'b0, 5'd0, 32'h0);
    check_eq("uart_rd_empty", apb_read_data_out, 32'h0000_0000);

    // Two received frames: 0x47 and 0xEB.
    send_byte(8'h47, 1'b1);
    send_byte(8'hEB, 1'b1);
    tick();
    apb_op(2'b10, 1'b0, 5'd0, 32'h0);
    check_eq("uart_rd_47", apb_read_data_out, 32'h0000_0047);
    apb_op(2'b10, 1'b0, 5'd0, 32'h0);
    check_eq("uart_rd_EB", apb_read_data_out, 32'h0000_00EB);
    apb_op(2'b10, 1'b0, 5'd0, 32'h0);
    check_eq("uart_rd_drained", apb_read_data_out, 32'h0000_0000);

    // Framing error: low stop bit discards the byte.
    send_byte(8'h5A, 1'b0);
    tick();
    apb_op(2'b10, 1'b0, 5'd0, 32'h0);
    check_eq("uart_framing_err", apb_read_data_out, 32'h0000_0000);

    // Pop of the empty FIFO on the same edge the stop bit pushes a byte.
    fork
      send_byte(8'h3C, 1'b1);
      begin
        repeat (7) tick();
        apb_op(2'b10, 1'b0, 5'd0, 32'h0);
      end
    join
    check_eq("pop_empty_with_push", apb_read_data_out, 32'h0000_0000);
    apb_op(2'b10, 1'b0, 5'd0, 32'h0);
    check_eq("pushed_byte_kept", apb_read_data_out, 32'h0000_003C);

    // Nine frames into an 8-deep FIFO: the ninth is dropped.
    for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      apb_op(2'b10, 1'b0, 5'd0, 32'h0);
      check_eq($sformatf("fifo_full_rd%0d", i), apb_read_data_out, 32'h10 + 32'(i));
    end
    apb_op(2'b10, 1'b0, 5'd0, 32'h0);
    check_eq("fifo_overflow_dropped", apb_read_data_out, 32'h0000_0000);

    // Reset in the middle of an rx frame, after memory writes.
    apb_op(2'b01, 1'b1, 5'd5, 32'h5A5A_5A5A);
    apb_op(2'b01, 1'b0, 5'd5, 32'h0);
    check_eq("pre_reset_a5", apb_read_data_out, 32'h5A5A_5A5A);
    rx = 1'b0; tick();
    rx = 1'b1; tick();
    rx = 1'b0; tick();
    Reset = 1'b1; rx = 1'b1;
    tick();
    Reset = 1'b0;
    check_eq("mid_reset_out", apb_read_data_out, 32'h0000_0000);
    repeat (12) tick();
    apb_op(2'b10, 1'b0, 5'd0, 32'h0);
    check_eq("partial_frame_discarded", apb_read_data_out, 32'h0000_0000);
    apb_op(2'b01, 1'b0, 5'd5, 32'h0);
    check_eq("mem_a5_cleared", apb_read_data_out, 32'h0000_0000);
    apb_op(2'b01, 1'b0, 5'd1, 32'h0);
    check_eq("mem_a1_cleared", apb_read_data_out, 32'h0000_0000);
    check_eq("post_reset_tx_idle", {31'h0, dut.uart_tx}, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
